digitron_scan_display: RTL and testbench
========================================

# digitron_scan_display

Parametrised multiplexed 7-segment scan driver, successor to the fixed six-digit clock display. Takes DIGITS packed BCD/hex nibbles and time-multiplexes them onto one shared segment bus with one-cold digit selects. Adds:
- per-digit decimal point, blanking and blinking;
- a static hold/override mode;
- a frame strobe.

Sits between the clock/calendar counters and the board's digit pins.

## Interface
Parameters:
- DIGITS, 6, number of scanned digits, legal 2..8
- SCAN_DIV, 200, CLK cycles each digit stays selected, legal ≥2
- BLINK_DIV, 250, full scan frames per blink half-period, legal ≥1

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST  in  1  reset, synchronous, active-high
- Digit_In  in  4*DIGITS  nibble for digit i at [4i+3:4i]; digit 0 is rightmost
- Dp_In  in  DIGITS  decimal point enable per digit
- Blank_Mask  in  DIGITS  1 = digit i dark (select still scanned, segments 0)
- Blink_Mask  in  DIGITS  1 = digit i blinks
- Hold_En  in  1  1 = static override display on digit 0
- Hold_Value  in  4  nibble shown while Hold_En=1
- Digitron_Out  out  8  segments, active-high, bit7 = dp, bits6:0 = g..a
- DigitronCS_Out  out  DIGITS  digit selects, active-low, one-cold while scanning
- Frame_Tick  out  1  one-cycle pulse at end of each full scan frame

## Operation
- Scan counter div_cnt runs 0..SCAN_DIV-1.
- At div_cnt = SCAN_DIV-1:
  - div_cnt wraps to 0.
  - Digit index idx advances: idx+1, or 0 when idx = DIGITS-1.
- Frame_Tick = 1 in exactly the cycle where div_cnt = SCAN_DIV-1 and idx = DIGITS-1.
- Segment decode, standard codes (g..a):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F
  - A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
- Registered output, normal mode:
  - DigitronCS_Out = all ones except bit idx = 0.
  - Digitron_Out = {Dp_In[idx], decode(Digit_In[idx])}.
  - Both fields are forced to 8'h00 if Blank_Mask[idx] is set, or if the blink phase is 1 and Blink_Mask[idx] is set.
- Hold mode (Hold_En = 1):
  - DigitronCS_Out = only bit 0 low.
  - Digitron_Out = {1'b0, decode(Hold_Value)}; Blank/Blink masks are ignored.
  - div_cnt, idx, Frame_Tick and blink logic keep running.
  - On Hold_En fall, scanning resumes at the current idx on the next registered update, with no restart.
- Counter widths: div_cnt uses $clog2(SCAN_DIV) bits, idx uses $clog2(DIGITS) bits, blink frame counter uses $clog2(BLINK_DIV) bits. Counters never exceed their terminal value.

## Timing
- Reset values: Digitron_Out = 8'h00, DigitronCS_Out = all ones (all digits off), Frame_Tick = 0, div_cnt = 0, idx = 0, blink phase = 0 (visible), blink counter = 0.
- RST asserted mid-frame takes effect at the next edge and overrides all other activity.
- First edge after RST falls: outputs show digit 0.
- Latency: Digitron_Out and DigitronCS_Out are registered together. Any change on Digit_In, masks or Hold_En while a digit is selected appears 1 cycle later.
- Select and segments always change on the same edge, so no cycle ever shows new segments with an old select.
- Digit dwell time: SCAN_DIV cycles. Frame period: DIGITS*SCAN_DIV cycles.
- Blink: the phase toggles on the edge following the BLINK_DIV-th Frame_Tick since the last toggle. Half-period = BLINK_DIV*DIGITS*SCAN_DIV cycles.
- Frame_Tick is combinational from the counters, valid in the cycle described above, never asserted during RST.

## Configuration
- DIGITRON_BLINK_EN defined: blink frame counter and phase register exist and Blink_Mask behaves as above.
- Macro undefined: no blink logic is synthesised, Blink_Mask is ignored (port kept, unused), and phase is treated as constant 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset/scan, DIGITS=4, SCAN_DIV=3, Digit_In=16'h4321, masks 0:
  - After RST falls, DigitronCS_Out steps E, D, B, 7, each for 3 cycles.
  - Digitron_Out steps 06, 5B, 4F, 66.
  - Frame_Tick is high once every 12 cycles.
- Hex and dp, Digit_In=16'hFA0b, Dp_In=4'b0010:
  - Segments are 7C, BF, 77, 71 (bit7 set on digit 1 only).
- Blank mid-frame: set Blank_Mask[2] while digit 2 is selected:
  - Digitron_Out becomes 00 the next cycle; CS still shows B.
- Blink, with DIGITRON_BLINK_EN, BLINK_DIV=2, Blink_Mask=4'b0001:
  - Digit 0 is dark for frames 3–4, lit for frames 5–6, and so on.
  - Without the macro, digit 0 is never dark.
- Hold: assert Hold_En with Hold_Value=5 while idx=2:
  - Next cycle CS=E and Digitron_Out=6D.
  - Frame_Tick keeps its 12-cycle period.
  - After Hold_En falls, the display resumes at the running idx.
- RST pulsed mid-frame during hold:
  - Next cycle outputs are 00 and all-ones CS.
  - Then digit 0 is displayed, with the scan restarting from div_cnt=0.

Source files
------------

// File: rtl/digitron_scan_display_if.sv
// Bundle of digit data, per-digit masks, hold override and display pins for the scan driver.
// Latency: none (wiring only); the driver registers the display side.
// Backpressure: none; inputs are sampled levels and outputs free-run.
interface digitron_scan_display_if #(
  parameter int DIGITS = 6
);
  logic [4*DIGITS-1:0] Digit_In;
  logic [DIGITS-1:0]   Dp_In;
  logic [DIGITS-1:0]   Blank_Mask;
  logic [DIGITS-1:0]   Blink_Mask;
  logic                Hold_En;
  logic [3:0]          Hold_Value;
  logic [7:0]          Digitron_Out;
  logic [DIGITS-1:0]   DigitronCS_Out;
  logic                Frame_Tick;

  // Source side: counters/calendar logic driving values, observing the pins.
  modport master (
    output Digit_In, Dp_In, Blank_Mask, Blink_Mask, Hold_En, Hold_Value,
    input  Digitron_Out, DigitronCS_Out, Frame_Tick
  );

  // Display driver side.
  modport slave (
    input  Digit_In, Dp_In, Blank_Mask, Blink_Mask, Hold_En, Hold_Value,
    output Digitron_Out, DigitronCS_Out, Frame_Tick
  );
endinterface

// File: rtl/digitron_scan_display.sv
// Multiplexed 7-segment scan driver: DIGITS nibbles onto one segment bus, one-cold active-low selects.
// Latency: select and segments registered together, 1 cycle from any input change; Frame_Tick combinational.
// Backpressure: none; free-running. Blink logic only exists when DIGITRON_BLINK_EN is defined.
module digitron_scan_display #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 200,
  parameter int BLINK_DIV = 250
) (
  input  logic                   CLK,
  input  logic                   RST,
  digitron_scan_display_if.slave bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Standard g..a segment codes for hex nibbles.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // Scan counters: div_cnt dwells SCAN_DIV cycles per digit, idx walks digits.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             div_last;
  logic             idx_last;
  logic             frame_end;

  assign div_last  = (div_cnt_q == DIV_LAST);
  assign idx_last  = (idx_q == IDX_LAST);
  assign frame_end = div_last & idx_last;

  // Next-state for the dwell counter and the digit index.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    idx_d     = idx_q;
    if (div_last) begin
      div_cnt_d = '0;
      idx_d     = idx_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Scan counters keep running in hold mode so the frame cadence never changes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Frame pulse decoded straight from the counters, suppressed while in reset.
  assign bus.Frame_Tick = frame_end & ~RST;

  // ---------------------------------------------------------------------------
  // Blink phase: toggles after every BLINK_DIV completed frames.
  // ---------------------------------------------------------------------------
  logic blink_dark;

`ifdef DIGITRON_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  // Count frame ends; on the BLINK_DIV-th one flip the phase and restart.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // Blink state starts visible (phase 0) out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_dark = blink_phase_q & bus.Blink_Mask[idx_q];
`else
  // Blink disabled: phase is permanently visible and the mask is ignored.
  logic [DIGITS-1:0] unused_blink_mask;
  assign unused_blink_mask = bus.Blink_Mask;
  assign blink_dark        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output stage: select and segments come from one register so they always
  // change on the same edge and never pair a new pattern with a stale select.
  // ---------------------------------------------------------------------------
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] cs_q, cs_d;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_dark;

  assign cur_nib  = bus.Digit_In[{idx_q, 2'b00} +: 4];
  assign cur_dp   = bus.Dp_In[idx_q];
  assign cur_dark = bus.Blank_Mask[idx_q] | blink_dark;

  // Pick the pattern for the digit being scanned, or the static hold pattern.
  always_comb begin
    seg_d = 8'h00;
    cs_d  = '1;
    if (bus.Hold_En) begin
      // Hold pins the display on digit 0, dp off, masks ignored.
      cs_d  = ~DIGITS'(1);
      seg_d = {1'b0, seg_decode(bus.Hold_Value)};
    end else begin
      // Blanked digits keep their select slot so the scan cadence is steady.
      cs_d = ~(DIGITS'(1) << idx_q);
      if (!cur_dark) begin
        seg_d = {cur_dp, seg_decode(cur_nib)};
      end
    end
  end

  // Reset turns every digit off and clears the segment bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_q <= 8'h00;
      cs_q  <= '1;
    end else begin
      seg_q <= seg_d;
      cs_q  <= cs_d;
    end
  end

  assign bus.Digitron_Out   = seg_q;
  assign bus.DigitronCS_Out = cs_q;

endmodule

// File: tb/tb_digitron_scan_display.sv
// Self-checking bench for digitron_scan_display (DIGITS=4, SCAN_DIV=3, BLINK_DIV=2).
// Reference model works from elapsed post-reset cycles: digit = (t/S)%D, frame = t/(D*S).
// Blink expectations follow DIGITRON_BLINK_EN so the bench suits either build.
module tb_digitron_scan_display;
  localparam int D  = 4;
  localparam int S  = 3;
  localparam int BD = 2;
  localparam int FR = D * S;
`ifdef DIGITRON_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  digitron_scan_display_if #(.DIGITS(D)) bus();

  digitron_scan_display #(
    .DIGITS   (D),
    .SCAN_DIV (S),
    .BLINK_DIV(BD)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: number of non-reset edges since the last reset.
  int         k = 0;
  logic [7:0] exp_seg;
  logic [3:0] exp_cs;
  logic       exp_ft;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] cs_scan  [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] seg_4321 [4]  = '{8'h06, 8'h5B, 8'h4F, 8'h66};

  // Pattern the display should latch given elapsed cycles kk and current inputs.
  function automatic void model(input int kk, output logic [7:0] s, output logic [3:0] c);
    int   idx;
    int   frame;
    bit   ph;
    logic [3:0] nib;
    idx   = (kk / S) % D;
    frame = kk / FR;
    ph    = BLINK_ON && (((frame / BD) % 2) == 1);
    if (bus.Hold_En) begin
      c = 4'b1110;
      s = {1'b0, seg_tab[bus.Hold_Value]};
    end else begin
      c      = 4'hF;
      c[idx] = 1'b0;
      nib    = bus.Digit_In[4*idx +: 4];
      if (bus.Blank_Mask[idx] || (ph && bus.Blink_Mask[idx])) s = 8'h00;
      else s = {bus.Dp_In[idx], seg_tab[nib]};
    end
  endfunction

  // Advance one clock; expectations are latched from pre-edge inputs, sampled 1ns after the edge.
  task automatic tick();
    logic [7:0] s;
    logic [3:0] c;
    int kn;
    if (rst) begin
      s = 8'h00; c = 4'hF; kn = 0;
    end else begin
      model(k, s, c);
      kn = k + 1;
    end
    @(posedge clk);
    #1;
    exp_seg = s;
    exp_cs  = c;
    k       = kn;
    exp_ft  = !rst && ((k % FR) == FR - 1);
  endtask

  task automatic clear_inputs();
    bus.Digit_In   = 16'h0000;
    bus.Dp_In      = 4'h0;
    bus.Blank_Mask = 4'h0;
    bus.Blink_Mask = 4'h0;
    bus.Hold_En    = 1'b0;
    bus.Hold_Value = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Digit_In   = 16'h8888;
    bus.Dp_In      = 4'hF;
    bus.Blank_Mask = 4'h0;
    bus.Blink_Mask = 4'h0;
    bus.Hold_En    = 1'b0;
    bus.Hold_Value = 4'h8;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (bus.Digitron_Out !== 8'h00) begin
        errors++; $display("FAIL reset_seg got %h want 00", bus.Digitron_Out);
      end
      checks++;
      if (bus.DigitronCS_Out !== 4'hF) begin
        errors++; $display("FAIL reset_cs got %h want F", bus.DigitronCS_Out);
      end
      checks++;
      if (bus.Frame_Tick !== 1'b0) begin
        errors++; $display("FAIL reset_ft got %b want 0", bus.Frame_Tick);
      end
    end
  endtask

  task automatic test_scan();
    int nft;
    int d;
    do_reset();
    bus.Digit_In = 16'h4321;
    nft = 0;
    for (int i = 1; i <= 2 * FR; i++) begin
      tick();
      d = ((i - 1) / S) % D;
      checks++;
      if (bus.DigitronCS_Out !== cs_scan[d]) begin
        errors++; $display("FAIL scan_cs cyc %0d got %h want %h", i, bus.DigitronCS_Out, cs_scan[d]);
      end
      checks++;
      if (bus.Digitron_Out !== seg_4321[d]) begin
        errors++; $display("FAIL scan_seg cyc %0d got %h want %h", i, bus.Digitron_Out, seg_4321[d]);
      end
      checks++;
      if (bus.Frame_Tick !== ((i % FR) == FR - 1)) begin
        errors++; $display("FAIL scan_ft cyc %0d got %b", i, bus.Frame_Tick);
      end
      if (bus.Frame_Tick === 1'b1) nft++;
    end
    checks++;
    if (nft != 2) begin
      errors++; $display("FAIL scan_ft_count got %0d want 2", nft);
    end
  endtask

  task automatic test_hex_dp();
    logic [7:0] want [4] = '{8'h7C, 8'hBF, 8'h77, 8'h71};
    int d;
    do_reset();
    bus.Digit_In = 16'hFA0B;
    bus.Dp_In    = 4'b0010;
    for (int i = 1; i <= FR; i++) begin
      tick();
      d = ((i - 1) / S) % D;
      checks++;
      if (bus.Digitron_Out !== want[d]) begin
        errors++; $display("FAIL hexdp_seg cyc %0d got %h want %h", i, bus.Digitron_Out, want[d]);
      end
    end
  endtask

  task automatic test_blank_mid();
    do_reset();
    bus.Digit_In = 16'h4321;
    for (int i = 1; i <= 7; i++) tick();
    checks++;
    if (bus.DigitronCS_Out !== 4'hB || bus.Digitron_Out !== 8'h4F) begin
      errors++; $display("FAIL blank_pre got %h/%h want B/4F", bus.DigitronCS_Out, bus.Digitron_Out);
    end
    bus.Blank_Mask = 4'b0100;
    tick();
    checks++;
    if (bus.Digitron_Out !== 8'h00) begin
      errors++; $display("FAIL blank_seg got %h want 00", bus.Digitron_Out);
    end
    checks++;
    if (bus.DigitronCS_Out !== 4'hB) begin
      errors++; $display("FAIL blank_cs got %h want B", bus.DigitronCS_Out);
    end
    tick();
    tick();
    checks++;
    if (bus.DigitronCS_Out !== 4'h7 || bus.Digitron_Out !== 8'h66) begin
      errors++; $display("FAIL blank_next got %h/%h want 7/66", bus.DigitronCS_Out, bus.Digitron_Out);
    end
    bus.Blank_Mask = 4'h0;
  endtask

  task automatic test_blink();
    int  f;
    bit  dark;
    logic [7:0] want;
    do_reset();
    bus.Digit_In   = 16'h4321;
    bus.Blink_Mask = 4'b0001;
    for (int i = 1; i <= 6 * FR; i++) begin
      tick();
      if ((((i - 1) / S) % D) == 0) begin
        f    = (i - 1) / FR;
        dark = BLINK_ON && (((f / BD) % 2) == 1);
        want = dark ? 8'h00 : 8'h06;
        checks++;
        if (bus.Digitron_Out !== want || bus.DigitronCS_Out !== 4'hE) begin
          errors++;
          $display("FAIL blink cyc %0d got %h/%h want E/%h", i, bus.DigitronCS_Out, bus.Digitron_Out, want);
        end
      end
    end
    bus.Blink_Mask = 4'h0;
  endtask

  task automatic test_hold();
    int nft;
    do_reset();
    bus.Digit_In = 16'h4321;
    for (int i = 1; i <= 6; i++) tick();
    bus.Hold_En    = 1'b1;
    bus.Hold_Value = 4'h5;
    nft = 0;
    for (int n = 1; n <= 2 * FR; n++) begin
      tick();
      checks++;
      if (bus.DigitronCS_Out !== 4'hE || bus.Digitron_Out !== 8'h6D) begin
        errors++; $display("FAIL hold_out n %0d got %h/%h want E/6D", n, bus.DigitronCS_Out, bus.Digitron_Out);
      end
      checks++;
      if (bus.Frame_Tick !== ((k % FR) == FR - 1)) begin
        errors++; $display("FAIL hold_ft n %0d got %b", n, bus.Frame_Tick);
      end
      if (bus.Frame_Tick === 1'b1) nft++;
    end
    checks++;
    if (nft != 2) begin
      errors++; $display("FAIL hold_ft_count got %0d want 2", nft);
    end
    bus.Hold_En = 1'b0;
    tick();
    checks++;
    if (bus.DigitronCS_Out !== 4'hB || bus.Digitron_Out !== 8'h4F) begin
      errors++; $display("FAIL hold_resume got %h/%h want B/4F", bus.DigitronCS_Out, bus.Digitron_Out);
    end
  endtask

  task automatic test_reset_mid_hold();
    int d;
    do_reset();
    bus.Digit_In = 16'h4321;
    for (int i = 1; i <= 5; i++) tick();
    bus.Hold_En    = 1'b1;
    bus.Hold_Value = 4'h5;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.Digitron_Out !== 8'h00 || bus.DigitronCS_Out !== 4'hF || bus.Frame_Tick !== 1'b0) begin
      errors++; $display("FAIL midrst got %h/%h/%b want F/00/0",
                         bus.DigitronCS_Out, bus.Digitron_Out, bus.Frame_Tick);
    end
    rst = 1'b0;
    bus.Hold_En = 1'b0;
    for (int i = 1; i <= FR; i++) begin
      tick();
      d = ((i - 1) / S) % D;
      checks++;
      if (bus.DigitronCS_Out !== cs_scan[d] || bus.Digitron_Out !== seg_4321[d]) begin
        errors++; $display("FAIL midrst_scan cyc %0d got %h/%h want %h/%h",
                           i, bus.DigitronCS_Out, bus.Digitron_Out, cs_scan[d], seg_4321[d]);
      end
      checks++;
      if (bus.Frame_Tick !== (i == FR - 1)) begin
        errors++; $display("FAIL midrst_ft cyc %0d got %b", i, bus.Frame_Tick);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.Digit_In   = 16'($urandom);
      bus.Dp_In      = 4'($urandom);
      bus.Blank_Mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      bus.Blink_Mask = 4'($urandom);
      bus.Hold_En    = ($urandom_range(0, 7) == 0);
      bus.Hold_Value = 4'($urandom);
      rst            = ($urandom_range(0, 49) == 0);
      tick();
      checks++;
      if (bus.Digitron_Out !== exp_seg) begin
        errors++; $display("FAIL rand_seg n %0d got %h want %h", n, bus.Digitron_Out, exp_seg);
      end
      checks++;
      if (bus.DigitronCS_Out !== exp_cs) begin
        errors++; $display("FAIL rand_cs n %0d got %h want %h", n, bus.DigitronCS_Out, exp_cs);
      end
      checks++;
      if (bus.Frame_Tick !== exp_ft) begin
        errors++; $display("FAIL rand_ft n %0d got %b want %b", n, bus.Frame_Tick, exp_ft);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_scan();
    test_hex_dp();
    test_blank_mid();
    test_blink();
    test_hold();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
